spi_mem_ctrl: RTL and testbench
===============================

# spi_mem_ctrl

Transaction sequencer and two-port arbiter sitting between the CPU and the byte-level SPI shifter (`spi_core`). It accepts single-byte read and write requests from the instruction-fetch port and the data port. It grants one request at a time and drives chip-select. It issues the command byte, the 16-bit address and the data byte through the shifter's `data_tx`/`txn_start`/`txn_done` handshake, then returns read data to the granted requester.

## Interface
Parameters:
- `CMD_READ`, default 8'h03, SPI memory read opcode.
- `CMD_WRITE`, default 8'h02, SPI memory write opcode.

Ports:
- `clk` in 1: single clock; shared with `spi_core`.
- `rst_n` in 1: reset, synchronous, active-low; shared with `spi_core`.
- `if_req` in 1: fetch read request; level, held until `if_ack`.
- `if_addr` in 16: fetch byte address.
- `if_ack` out 1: one-cycle completion pulse for the fetch port.
- `d_req` in 1: data request; level, held until `d_ack`.
- `d_we` in 1: data port operation, 1 = write, 0 = read.
- `d_addr` in 16: data byte address.
- `d_wdata` in 8: write byte.
- `d_ack` out 1: one-cycle completion pulse for the data port.
- `rdata` out 8: read byte; valid in the ack cycle and held until the next read completes.
- `busy` out 1: high from grant through the HOLD state.
- `spi_cs_n` out 1: memory chip select, active low.
- `core_data_tx` out 8: to `spi_core.data_tx`.
- `core_txn_start` out 1: to `spi_core.txn_start`; registered, one-cycle pulse.
- `core_data_rx` in 8: from `spi_core.data_rx`.
- `core_txn_done` in 1: from `spi_core.txn_done`; high means the shifter is idle.

## Operation
- Reset values: `spi_cs_n`=1; `if_ack`, `d_ack`, `busy`, `core_txn_start`=0; `rdata`, `core_data_tx`=8'h00; state IDLE.
- States: IDLE, SETUP, CMD, ADDR_HI, ADDR_LO, DATA, HOLD. Each byte state has two sub-phases:
  - issue: `core_txn_start`=1 for exactly one cycle, with `core_data_tx` set to the byte.
  - wait: wait until `core_txn_done`=1.
- IDLE: requests are sampled only here. If `d_req`=1 the data port wins; otherwise `if_req`=1 is granted. On grant, latch port id, `addr`, `we` (fetch forces 0) and `wdata`, then go to SETUP.
- SETUP: `spi_cs_n` drives 0, no byte issued → CMD.
- CMD: sends `CMD_WRITE` if `we`, else `CMD_READ` → ADDR_HI (addr[15:8]) → ADDR_LO (addr[7:0]) → DATA.
- DATA: a write sends the latched `wdata`. A read sends 8'h00 and, on done, loads `core_data_rx` into `rdata`. Then go to HOLD.
- HOLD: `spi_cs_n`=1 and one-cycle ack on the granted port → IDLE.
- Arbitration is fixed priority, data over fetch. A losing request stays pending and is evaluated in the next IDLE. Continuous `d_req` may starve fetch; this is accepted, because the CPU never holds both.
- A request deasserted before its ack is still completed and still acked. Latched operands are not re-sampled.
- Reset mid-transaction: next cycle all outputs are at reset values, `spi_cs_n`=1, and no ack is issued. `spi_core` resets in the same cycle.
- Address increments and wrap are not handled here; every request is one byte at one explicit address.

## Timing
- Cycle 0: req sampled in IDLE, grant.
- Cycle 1: SETUP, `spi_cs_n` low.
- Cycle 2: first `core_txn_start`.
- Byte slot = 18 cycles: start at S, `txn_done` low S+1..S+16, done seen high at S+17, next start at S+18.
- Starts at cycles 2, 20, 38, 56. Last done is seen at 73.
- Cycle 74: HOLD, ack, `rdata` valid, `spi_cs_n` high.
- Cycle 75: IDLE, can grant. The earliest next `spi_cs_n` low is cycle 76, so CS stays high for ≥2 cycles.
- Request-to-ack latency is 74 cycles for both reads and writes.
- `core_txn_start` is never asserted while `core_txn_done`=0.

## Test plan
- Fetch read at 16'h1234, SPI model returns 8'hA5: the shifter sees MOSI bytes 03,12,34,00; `if_ack` pulses at cycle 74; `rdata`=8'hA5; `spi_cs_n` is low exactly over cycles 1–73.
- Data write 8'h5A to 16'hFFFF: MOSI carries 02,FF,FF,5A; `d_ack` pulses at cycle 74; `rdata` is unchanged.
- `if_req` and `d_req` rise in the same cycle: the data port is served first and acked at 74. Fetch is granted at 75 and acked at 149. Both acks stay single-cycle.
- `rst_n` is pulsed low during ADDR_LO: the next cycle has `spi_cs_n`=1, `busy`=0, no ack. A subsequent read still completes correctly in 74 cycles.
- `d_req` is dropped after grant: the transaction still completes and `d_ack` pulses once. With no further requests, the controller then idles with `spi_cs_n`=1.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: arbitrates fetch/data byte requests (data wins) and frames each one
// as CS low, opcode, addr hi, addr lo, data byte on spi_core, then CS high with an ack.
module spi_mem_ctrl #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic [7:0]  core_data_tx,
  output logic        core_txn_start,
  input  logic [7:0]  core_data_rx,
  input  logic        core_txn_done
);

  // state   | meaning
  // IDLE    | sample requests, grant data port before fetch port
  // SETUP   | chip select asserted, nothing issued yet
  // CMD     | opcode byte
  // ADDR_HI | address[15:8]
  // ADDR_LO | address[7:0]
  // DATA    | write byte or read dummy; rx captured on done
  // HOLD    | chip select released, ack to granted port
  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR_HI, ADDR_LO, DATA, HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_port_d;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic [7:0]  r_data_tx;
  logic        r_txn_start;
  logic        w_start_nxt;
  logic [7:0]  w_tx_nxt;
  logic        w_grant;
  logic        w_grant_d;
  logic        w_load_rdata;
  logic        w_byte_done;

  // A byte state is in its issue cycle exactly when r_txn_start is high.
  assign w_byte_done = !r_txn_start && core_txn_done;

  always_comb begin
    w_state_nxt  = r_state;
    w_start_nxt  = 1'b0;
    w_tx_nxt     = r_data_tx;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    w_load_rdata = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req || if_req) begin
          w_grant     = 1'b1;
          w_grant_d   = d_req;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        w_state_nxt = CMD;
        w_start_nxt = 1'b1;
        w_tx_nxt    = r_we ? CMD_WRITE : CMD_READ;
      end
      CMD: begin
        if (w_byte_done) begin
          w_state_nxt = ADDR_HI;
          w_start_nxt = 1'b1;
          w_tx_nxt    = r_addr[15:8];
        end
      end
      ADDR_HI: begin
        if (w_byte_done) begin
          w_state_nxt = ADDR_LO;
          w_start_nxt = 1'b1;
          w_tx_nxt    = r_addr[7:0];
        end
      end
      ADDR_LO: begin
        if (w_byte_done) begin
          w_state_nxt = DATA;
          w_start_nxt = 1'b1;
          w_tx_nxt    = r_we ? r_wdata : 8'h00;
        end
      end
      DATA: begin
        if (w_byte_done) begin
          w_state_nxt  = HOLD;
          w_load_rdata = !r_we;
        end
      end
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_txn_start <= 1'b0;
      r_data_tx   <= 8'h00;
      r_rdata     <= 8'h00;
      r_port_d    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_txn_start <= w_start_nxt;
      r_data_tx   <= w_tx_nxt;
      if (w_grant) begin
        r_port_d <= w_grant_d;
        r_we     <= w_grant_d & d_we;
        r_addr   <= w_grant_d ? d_addr : if_addr;
        r_wdata  <= d_wdata;
      end
      if (w_load_rdata) r_rdata <= core_data_rx;
    end
  end

  assign spi_cs_n       = (r_state == IDLE) || (r_state == HOLD);
  assign busy           = (r_state != IDLE);
  assign if_ack         = (r_state == HOLD) && !r_port_d;
  assign d_ack          = (r_state == HOLD) && r_port_d;
  assign rdata          = r_rdata;
  assign core_data_tx   = r_data_tx;
  assign core_txn_start = r_txn_start;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: spi_core/memory model, directed table, corner sequences,
// and random requests checked against a flat memory reference.
module tb_spi_mem_ctrl;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [7:0]  d_wdata = 8'h00;
  logic        d_ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        spi_cs_n;
  logic [7:0]  core_data_tx;
  logic        core_txn_start;
  logic [7:0]  core_data_rx = 8'h00;
  logic        core_txn_done = 1'b1;

  always #5 clk = ~clk;

  spi_mem_ctrl #(.CMD_READ(CMD_READ), .CMD_WRITE(CMD_WRITE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .busy(busy), .spi_cs_n(spi_cs_n),
    .core_data_tx(core_data_tx), .core_txn_start(core_txn_start),
    .core_data_rx(core_data_rx), .core_txn_done(core_txn_done)
  );

  logic [7:0] slave_mem [0:65535];
  logic [7:0] ref_mem   [0:65535];
  logic [7:0] mosi_q[$];
  logic [7:0] sh_bytes [0:3];
  int         sh_idx = 0;
  int         sh_cnt = 0;

  // spi_core + SPI memory: done low for 16 cycles after each start, memory acts on byte 4
  always @(posedge clk) begin
    if (!rst_n) begin
      core_txn_done <= 1'b1;
      sh_cnt = 0;
      sh_idx = 0;
    end else begin
      if (spi_cs_n) sh_idx = 0;
      if (core_txn_start) begin
        mosi_q.push_back(core_data_tx);
        core_txn_done <= 1'b0;
        sh_cnt = 16;
        if (sh_idx < 4) sh_bytes[sh_idx] = core_data_tx;
        if (sh_idx == 3 && sh_bytes[0] == CMD_READ) begin
          core_data_rx <= slave_mem[{sh_bytes[1], sh_bytes[2]}];
        end else begin
          if (sh_idx == 3 && sh_bytes[0] == CMD_WRITE)
            slave_mem[{sh_bytes[1], sh_bytes[2]}] = core_data_tx;
          core_data_rx <= 8'($urandom);
        end
        sh_idx++;
      end else if (sh_cnt > 0) begin
        sh_cnt--;
        if (sh_cnt == 0) core_txn_done <= 1'b1;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input string tag, input bit is_d, input bit we, input logic [15:0] addr,
                         input logic [7:0] wdata, input bit drop, input logic [7:0] exp_rdata,
                         input logic [31:0] exp_mosi);
    int ack_at, acks, wrong_acks, cs_low, cs_first, cs_last, viol;
    logic [7:0]  rd_at_ack;
    logic [31:0] got_mosi;
    ack_at = -1; acks = 0; wrong_acks = 0; cs_low = 0; cs_first = -1; cs_last = -1; viol = 0;
    rd_at_ack = 8'h00;
    mosi_q.delete();
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
      d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 8'($urandom);
    end
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (drop && k == 2) begin d_req = 1'b0; if_req = 1'b0; end
      if (!spi_cs_n) begin
        cs_low++;
        if (cs_first < 0) cs_first = k;
        cs_last = k;
      end
      if (core_txn_start && !core_txn_done) viol++;
      if (is_d ? d_ack : if_ack) begin
        acks++;
        if (ack_at < 0) begin ack_at = k; rd_at_ack = rdata; end
        d_req = 1'b0; if_req = 1'b0;
      end
      if (is_d ? if_ack : d_ack) wrong_acks++;
    end
    got_mosi = (mosi_q.size() == 4) ? {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]} : 32'hDEADBEEF;
    chk($sformatf("%s.ack_cycle", tag), ack_at, 74);
    chk($sformatf("%s.ack_count", tag), acks, 1);
    chk($sformatf("%s.other_ack", tag), wrong_acks, 0);
    chk($sformatf("%s.cs_first", tag), cs_first, 1);
    chk($sformatf("%s.cs_last", tag), cs_last, 73);
    chk($sformatf("%s.cs_low_cycles", tag), cs_low, 73);
    chk($sformatf("%s.start_while_busy", tag), viol, 0);
    chk($sformatf("%s.mosi_bytes", tag), mosi_q.size(), 4);
    chk($sformatf("%s.mosi", tag), int'(got_mosi), int'(exp_mosi));
    chk($sformatf("%s.rdata", tag), int'(rd_at_ack), int'(exp_rdata));
    chk($sformatf("%s.idle_busy", tag), int'(busy), 0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          pre;
    logic [7:0]  preval;
    bit          drop;
    logic [7:0]  exp_rdata;
    logic [31:0] exp_mosi;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] last_rd;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d_at, i_at, d_acks, i_acks, acks, csl;
    logic [7:0] rd_d, rd_i;
    logic [63:0] got8;

    for (int a = 0; a < 65536; a++) begin
      logic [15:0] a16;
      a16 = 16'(a);
      slave_mem[a] = a16[7:0] ^ a16[15:8] ^ 8'h5C;
      ref_mem[a]   = a16[7:0] ^ a16[15:8] ^ 8'h5C;
    end

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, 8'hA5, 1'b0, 8'hA5, 32'h03123400};
    vecs[1] = '{1'b1, 1'b1, 16'hFFFF, 8'h5A, 1'b1, 8'h11, 1'b0, 8'hA5, 32'h02FFFF5A};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5A, 32'h03FFFF00};
    vecs[3] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 8'hC3, 1'b1, 8'hC3, 32'h03000000};
    vecs[4] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 1'b1, 8'h7E, 1'b1, 8'h7E, 32'h0300FF00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.cs_n", int'(spi_cs_n), 1);
    chk("reset.if_ack", int'(if_ack), 0);
    chk("reset.d_ack", int'(d_ack), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.txn_start", int'(core_txn_start), 0);
    chk("reset.rdata", int'(rdata), 0);
    chk("reset.data_tx", int'(core_data_tx), 0);
    rst_n = 1'b1;
    last_rd = 8'h00;

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].pre) begin
        slave_mem[vecs[v].addr] = vecs[v].preval;
        ref_mem[vecs[v].addr]   = vecs[v].preval;
      end
      run_txn($sformatf("vec%0d", v), vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
              vecs[v].drop, vecs[v].exp_rdata, vecs[v].exp_mosi);
      if (vecs[v].we) ref_mem[vecs[v].addr] = vecs[v].wdata;
      last_rd = vecs[v].exp_rdata;
    end

    // both ports request in the same cycle
    mosi_q.delete();
    d_at = -1; i_at = -1; d_acks = 0; i_acks = 0; rd_d = 8'h00; rd_i = 8'h00;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h2000;
    if_req = 1'b1; if_addr = 16'h3000;
    for (int k = 1; k <= 160; k++) begin
      @(posedge clk); #1;
      if (d_ack) begin d_acks++; if (d_at < 0) begin d_at = k; rd_d = rdata; end d_req = 1'b0; end
      if (if_ack) begin i_acks++; if (i_at < 0) begin i_at = k; rd_i = rdata; end if_req = 1'b0; end
    end
    got8 = (mosi_q.size() == 8) ? {mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3],
                                   mosi_q[4], mosi_q[5], mosi_q[6], mosi_q[7]} : 64'hDEAD;
    chk("both.d_ack_cycle", d_at, 74);
    chk("both.if_ack_cycle", i_at, 149);
    chk("both.d_ack_count", d_acks, 1);
    chk("both.if_ack_count", i_acks, 1);
    chk("both.mosi_first", int'(got8[63:32]), 32'h03200000);
    chk("both.mosi_second", int'(got8[31:0]), 32'h03300000);
    chk("both.rdata_d", int'(rd_d), int'(ref_mem[16'h2000]));
    chk("both.rdata_if", int'(rd_i), int'(ref_mem[16'h3000]));

    // reset pulse during ADDR_LO
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h4321;
    repeat (45) @(posedge clk);
    #1;
    chk("rst.cs_mid", int'(spi_cs_n), 0);
    rst_n = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    chk("rst.cs_n", int'(spi_cs_n), 1);
    chk("rst.busy", int'(busy), 0);
    chk("rst.if_ack", int'(if_ack), 0);
    chk("rst.txn_start", int'(core_txn_start), 0);
    chk("rst.data_tx", int'(core_data_tx), 0);
    chk("rst.rdata", int'(rdata), 0);
    rst_n = 1'b1;
    acks = 0; csl = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) acks++;
      if (!spi_cs_n) csl++;
    end
    chk("rst.no_ack", acks, 0);
    chk("rst.cs_stays_high", csl, 0);
    last_rd = 8'h00;
    run_txn("rst.after", 1'b0, 1'b0, 16'h4321, 8'h00, 1'b0, ref_mem[16'h4321], 32'h03432100);
    last_rd = ref_mem[16'h4321];

    for (int n = 0; n < 12; n++) begin
      bit          is_d, we, drop;
      logic [15:0] a;
      logic [7:0]  wd, er;
      logic [31:0] em;
      is_d = 1'($urandom);
      we   = is_d & 1'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        default: a = {8'hA0, 8'($urandom_range(0, 3))};
      endcase
      wd = 8'($urandom);
      er = we ? last_rd : ref_mem[a];
      em = {(we ? CMD_WRITE : CMD_READ), a, (we ? wd : 8'h00)};
      run_txn($sformatf("rand%0d", n), is_d, we, a, wd, drop, er, em);
      if (we) ref_mem[a] = wd;
      last_rd = er;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
